// File: rtl/sram_arb_pkg.sv
// Shared types for the dual-read SRAM arbiter: controller state and the
// per-read-port pending response slot.
package sram_arb_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } arb_state_t;

  // Slot field widths; must cover the arbiter's WIDTH and $clog2(NUM_REQ).
  localparam int unsigned SLOT_DATA_W = 32;
  localparam int unsigned SLOT_IDX_W  = 2;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_IDX_W-1:0]  idx;
    logic                   fwd;
    logic [SLOT_DATA_W-1:0] data;
  } pend_slot_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin picker: up to two grants per cycle, scanning from
// i_ptr, with the pointer for the following cycle.
module rr_pick2 #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IW-1:0]      i_ptr,
  output logic               o_g0_valid,
  output logic [IW-1:0]      o_g0_idx,
  output logic               o_g1_valid,
  output logic [IW-1:0]      o_g1_idx,
  output logic [IW-1:0]      o_next_ptr
);

  logic [IW:0]   w_scan;
  logic [IW-1:0] w_last;

  always_comb begin
    o_g0_valid = 1'b0;
    o_g0_idx   = '0;
    o_g1_valid = 1'b0;
    o_g1_idx   = '0;
    w_scan     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr + i stays below 2*NUM_REQ, so one conditional subtract is a full modulo.
      w_scan = {1'b0, i_ptr} + (IW + 1)'(i);
      if (w_scan >= (IW + 1)'(NUM_REQ)) begin
        w_scan = w_scan - (IW + 1)'(NUM_REQ);
      end
      if (i_valid[w_scan[IW-1:0]]) begin
        if (!o_g0_valid) begin
          o_g0_valid = 1'b1;
          o_g0_idx   = w_scan[IW-1:0];
        end else if (!o_g1_valid) begin
          o_g1_valid = 1'b1;
          o_g1_idx   = w_scan[IW-1:0];
        end
      end
    end

    w_last = o_g1_valid ? o_g1_idx : o_g0_idx;
    if (!o_g0_valid) begin
      o_next_ptr = i_ptr;
    end else if (w_last == IW'(NUM_REQ - 1)) begin
      o_next_ptr = '0;
    end else begin
      o_next_ptr = w_last + 1'b1;
    end
  end

endmodule

// File: rtl/sram_rd_arbiter.sv
// Shares one 1W2R SRAM between NUM_REQ readers and one writer: zero-fill after
// reset, two round-robin reads per cycle, same-cycle write forwarding.
module sram_rd_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned DEPTH   = 8,
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*AW-1:0]    i_req_addr,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  output logic [NUM_REQ*WIDTH-1:0] o_rsp_data,
  input  logic                     i_w_e,
  input  logic [AW-1:0]            i_w_addr,
  input  logic [WIDTH-1:0]         i_w_data,
  output logic                     o_w_ready,
  output logic                     o_sram_w_e,
  output logic [AW-1:0]            o_sram_w_addr,
  output logic [WIDTH-1:0]         o_sram_w_data,
  output logic                     o_sram_r0_e,
  output logic [AW-1:0]            o_sram_r0_addr,
  input  logic [WIDTH-1:0]         i_sram_r0_data,
  output logic                     o_sram_r1_e,
  output logic [AW-1:0]            o_sram_r1_addr,
  input  logic [WIDTH-1:0]         i_sram_r1_data,
  output logic                     o_init_busy
);

  arb_state_t    r_state, w_state_d;
  logic [AW-1:0] r_clr_cnt, w_clr_cnt_d;
  logic [IW-1:0] r_ptr, w_next_ptr;
  pend_slot_t    r_slot [2];
  pend_slot_t    w_slot_d [2];

  logic               w_run;
  logic               w_wr_acc;
  logic [NUM_REQ-1:0] w_req_gated;
  logic               w_gv [2];
  logic [IW-1:0]      w_gi [2];
  logic [AW-1:0]      w_rd_addr [2];
  logic [WIDTH-1:0]   w_sram_rd [2];
  logic [WIDTH-1:0]   w_port_data [2];
  logic [AW-1:0]      w_req_addr [NUM_REQ];
  logic [WIDTH-1:0]   w_rsp_lane [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign w_req_addr[k]                 = i_req_addr[k*AW +: AW];
    assign o_rsp_data[k*WIDTH +: WIDTH] = w_rsp_lane[k];
  end

  assign w_run       = (r_state == ST_RUN);
  assign w_wr_acc    = i_w_e & o_w_ready;
  assign w_req_gated = w_run ? i_req_valid : '0;
  assign w_sram_rd[0] = i_sram_r0_data;
  assign w_sram_rd[1] = i_sram_r1_data;

  rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_valid    (w_req_gated),
    .i_ptr      (r_ptr),
    .o_g0_valid (w_gv[0]),
    .o_g0_idx   (w_gi[0]),
    .o_g1_valid (w_gv[1]),
    .o_g1_idx   (w_gi[1]),
    .o_next_ptr (w_next_ptr)
  );

  always_comb begin
    w_state_d     = r_state;
    w_clr_cnt_d   = r_clr_cnt;
    o_init_busy   = 1'b0;
    o_w_ready     = 1'b0;
    o_sram_w_e    = 1'b0;
    o_sram_w_addr = '0;
    o_sram_w_data = '0;
    case (r_state)
      ST_CLEAR: begin
        o_init_busy   = 1'b1;
        // Reset forces this state, so gate the write off while reset is held.
        o_sram_w_e    = i_rst_n;
        o_sram_w_addr = r_clr_cnt;
        w_clr_cnt_d   = r_clr_cnt + 1'b1;
        if (r_clr_cnt == AW'(DEPTH - 1)) begin
          w_state_d   = ST_RUN;
          w_clr_cnt_d = '0;
        end
      end
      ST_RUN: begin
        o_w_ready     = 1'b1;
        o_sram_w_e    = i_w_e;
        o_sram_w_addr = i_w_addr;
        o_sram_w_data = i_w_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    for (int p = 0; p < 2; p++) begin
      if (w_gv[p]) begin
        o_req_ready[w_gi[p]] = 1'b1;
      end
      w_rd_addr[p]         = w_req_addr[w_gi[p]];
      w_slot_d[p].valid    = w_gv[p];
      w_slot_d[p].idx      = SLOT_IDX_W'(w_gi[p]);
      // The RAM returns stale data on a same-cycle collision; capture the write instead.
      w_slot_d[p].fwd      = w_wr_acc && (i_w_addr == w_rd_addr[p]);
      w_slot_d[p].data     = SLOT_DATA_W'(i_w_data);
    end
  end

  assign o_sram_r0_e    = w_gv[0];
  assign o_sram_r0_addr = w_rd_addr[0];
  assign o_sram_r1_e    = w_gv[1];
  assign o_sram_r1_addr = w_rd_addr[1];

  always_comb begin
    o_rsp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_rsp_lane[k] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      w_port_data[p] = r_slot[p].fwd ? WIDTH'(r_slot[p].data) : w_sram_rd[p];
      if (r_slot[p].valid) begin
        o_rsp_valid[IW'(r_slot[p].idx)] = 1'b1;
        w_rsp_lane[IW'(r_slot[p].idx)]  = w_port_data[p];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_ptr     <= '0;
      r_slot[0] <= '0;
      r_slot[1] <= '0;
    end else begin
      r_state   <= w_state_d;
      r_clr_cnt <= w_clr_cnt_d;
      r_ptr     <= w_next_ptr;
      r_slot[0] <= w_slot_d[0];
      r_slot[1] <= w_slot_d[1];
    end
  end

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Bench for sram_rd_arbiter: behavioural SRAM plus a reference model of the
// arbiter's visible behaviour, checked every cycle, with directed scenarios.
module tb_sram_rd_arbiter;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int NR = 4;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [AW-1:0]    req_addr_arr [NR];
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [NR*W-1:0]  rsp_data;
  logic             w_e = 1'b0;
  logic [AW-1:0]    w_addr = '0;
  logic [W-1:0]     w_data = '0;
  logic             w_ready, s_w_e, s_r0_e, s_r1_e, init_busy;
  logic [AW-1:0]    s_w_addr, s_r0_addr, s_r1_addr;
  logic [W-1:0]     s_w_data, s_r0_data, s_r1_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NR; k++) begin : g_pack
    assign req_addr[k*AW +: AW] = req_addr_arr[k];
  end

  sram_rd_arbiter #(.WIDTH(W), .DEPTH(D), .NUM_REQ(NR)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .i_req_addr     (req_addr),
    .o_req_ready    (req_ready),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .i_w_e          (w_e),
    .i_w_addr       (w_addr),
    .i_w_data       (w_data),
    .o_w_ready      (w_ready),
    .o_sram_w_e     (s_w_e),
    .o_sram_w_addr  (s_w_addr),
    .o_sram_w_data  (s_w_data),
    .o_sram_r0_e    (s_r0_e),
    .o_sram_r0_addr (s_r0_addr),
    .i_sram_r0_data (s_r0_data),
    .o_sram_r1_e    (s_r1_e),
    .o_sram_r1_addr (s_r1_addr),
    .i_sram_r1_data (s_r1_data),
    .o_init_busy    (init_busy)
  );

  // 1W2R RAM with registered reads; a same-address read sees the old value.
  logic [W-1:0] sram [D];
  initial begin
    for (int i = 0; i < D; i++) sram[i] = $urandom;
    s_r0_data = $urandom;
    s_r1_data = $urandom;
    for (int k = 0; k < NR; k++) req_addr_arr[k] = '0;
  end
  always @(posedge clk) begin
    if (s_r0_e) s_r0_data <= sram[s_r0_addr];
    if (s_r1_e) s_r1_data <= sram[s_r1_addr];
    if (s_w_e)  sram[s_w_addr] <= s_w_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lane(input logic [NR*W-1:0] d, input int k);
    return W'(d >> (k * W));
  endfunction

  // Reference model: logical memory contents where a read observes the write
  // issued in the same cycle.
  logic [W-1:0]  ref_mem [D];
  bit            m_clear = 1'b1;
  int            m_cnt = 0;
  int            m_ptr = 0;
  logic [NR-1:0] m_pv = '0;
  logic [W-1:0]  m_pd [NR];

  always @(negedge clk) begin : p_cmp
    int g [2];
    int ng;
    int k;
    logic [NR-1:0] exp_ready;
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_init_busy", init_busy, 1);
      chk("rst_sram_w_e", s_w_e, 0);
      chk("rst_sram_r0_e", s_r0_e, 0);
      chk("rst_sram_r1_e", s_r1_e, 0);
      m_clear = 1'b1;
      m_cnt   = 0;
      m_ptr   = 0;
      m_pv    = '0;
    end else begin
      for (int j = 0; j < NR; j++) begin
        chk("rsp_valid", rsp_valid[j], m_pv[j]);
        chk("rsp_data", lane(rsp_data, j), m_pv[j] ? m_pd[j] : '0);
      end
      m_pv = '0;
      if (m_clear) begin
        chk("clr_busy", init_busy, 1);
        chk("clr_w_ready", w_ready, 0);
        chk("clr_req_ready", req_ready, 0);
        chk("clr_r0_e", s_r0_e, 0);
        chk("clr_r1_e", s_r1_e, 0);
        chk("clr_w_e", s_w_e, 1);
        chk("clr_w_addr", s_w_addr, m_cnt);
        chk("clr_w_data", s_w_data, 0);
        ref_mem[m_cnt] = '0;
        m_cnt++;
        if (m_cnt == D) m_clear = 1'b0;
      end else begin
        chk("run_busy", init_busy, 0);
        chk("run_w_ready", w_ready, 1);
        chk("run_w_e", s_w_e, w_e);
        if (w_e) begin
          chk("run_w_addr", s_w_addr, w_addr);
          chk("run_w_data", s_w_data, w_data);
          ref_mem[w_addr] = w_data;
        end
        ng = 0;
        exp_ready = '0;
        for (int i = 0; i < NR; i++) begin
          k = (m_ptr + i) % NR;
          if (req_valid[k] && ng < 2) begin
            g[ng] = k;
            ng++;
            exp_ready[k] = 1'b1;
          end
        end
        chk("req_ready", req_ready, exp_ready);
        chk("r0_e", s_r0_e, ng >= 1);
        chk("r1_e", s_r1_e, ng >= 2);
        if (ng >= 1) chk("r0_addr", s_r0_addr, req_addr_arr[g[0]]);
        if (ng >= 2) chk("r1_addr", s_r1_addr, req_addr_arr[g[1]]);
        for (int j = 0; j < ng; j++) begin
          m_pv[g[j]] = 1'b1;
          m_pd[g[j]] = ref_mem[req_addr_arr[g[j]]];
        end
        if (ng > 0) m_ptr = (g[ng-1] + 1) % NR;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NR-1:0] exp_g [3];
    exp_g[0] = 4'b0011;
    exp_g[1] = 4'b1100;
    exp_g[2] = 4'b0011;

    repeat (3) step();
    rst_n = 1'b1;
    // Clear sequence: eight zero writes, then RUN.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("t1_busy", init_busy, c < 8);
      chk("t1_w_e", s_w_e, c < 8);
      chk("t1_w_ready", w_ready, c >= 8);
      if (c < 8) begin
        chk("t1_w_addr", s_w_addr, c);
        chk("t1_w_data", s_w_data, 0);
      end
      step();
    end

    // Write then read back.
    w_e = 1'b1; w_addr = 3; w_data = 32'hA5;
    step();
    w_e = 1'b0; req_valid = 4'b0100; req_addr_arr[2] = 3;
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 4'b0100);
    chk("t2_rsp_data", lane(rsp_data, 2), 32'hA5);
    step();

    // Grant requester 3 alone to bring the pointer back to 0.
    req_valid = 4'b1000; req_addr_arr[3] = 0;
    step();
    req_valid = '0;
    step();

    // All requesters busy: pairs alternate.
    for (int k = 0; k < NR; k++) req_addr_arr[k] = AW'(k);
    for (int c = 0; c < 4; c++) begin
      req_valid = (c < 3) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c < 3) chk("t3_ready", req_ready, exp_g[c]);
      if (c > 0) chk("t3_rsp_valid", rsp_valid, exp_g[c-1]);
      if (c == 2) chk("t3_rsp_data3", lane(rsp_data, 3), 32'hA5);
      step();
    end

    // Pointer is 2: requester 3 wins port 0, requester 1 port 1, pointer stays 2.
    req_valid = 4'b1010; req_addr_arr[1] = 1; req_addr_arr[3] = 6;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t5_ready", req_ready, 4'b1010);
      chk("t5_r0_addr", s_r0_addr, 6);
      chk("t5_r1_addr", s_r1_addr, 1);
      step();
    end
    req_valid = '0;
    step();

    // Same-cycle write and read are forwarded; the repeat read hits the RAM.
    w_e = 1'b1; w_addr = 5; w_data = 32'hDEADBEEF;
    req_valid = 4'b0010; req_addr_arr[1] = 5;
    step();
    w_e = 1'b0;
    @(negedge clk);
    chk("t4_rsp_valid", rsp_valid, 4'b0010);
    chk("t4_fwd_data", lane(rsp_data, 1), 32'hDEADBEEF);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t4_rsp_valid2", rsp_valid, 4'b0010);
    chk("t4_ram_data", lane(rsp_data, 1), 32'hDEADBEEF);
    step();

    // Random traffic, including collisions and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      req_valid = NR'($urandom);
      for (int k = 0; k < NR; k++) req_addr_arr[k] = AW'($urandom_range(0, D - 1));
      w_e = $urandom_range(0, 1) == 1;
      w_addr = ($urandom_range(0, 1) == 1) ? req_addr_arr[$urandom_range(0, NR - 1)]
                                            : AW'($urandom_range(0, D - 1));
      w_data = $urandom;
      step();
    end
    rst_n = 1'b1; req_valid = '0; w_e = 1'b0;
    repeat (10) step();

    // Reset with two reads outstanding: no pulses, full clear, old data gone.
    w_e = 1'b1; w_addr = 3; w_data = 32'h12345678;
    step();
    w_e = 1'b0; req_valid = 4'b0011; req_addr_arr[0] = 3; req_addr_arr[1] = 3;
    step();
    rst_n = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("t6_rsp_dropped", rsp_valid, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t6_busy", init_busy, 1);
      step();
    end
    req_valid = 4'b0001; req_addr_arr[0] = 3;
    @(negedge clk);
    chk("t6_busy_done", init_busy, 0);
    chk("t6_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 4'b0001);
    chk("t6_cleared", lane(rsp_data, 0), 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
